multi_nbit_seq: RTL and testbench
=================================

# multi_nbit_seq

Parametrised sequential shift-add multiplier; the next-generation successor to the fixed 16-bit `multi_16bit` block. It multiplies two WIDTH-bit operands in unsigned or two's-complement signed mode, selected per operation, with a start/done handshake and a busy flag. It sits in the arithmetic library alongside the other iterative datapath units and trades area for a latency of up to WIDTH cycles.

## Interface

- `WIDTH`, default 16: operand width in bits; legal range ≥ 2; the result is 2*WIDTH bits.

Ports:

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new multiply; level-sensitive; sampled only in IDLE.
- `signed_mode`  in  1  1 = two's-complement operands and result, 0 = unsigned; sampled with `start`.
- `ain`  in  WIDTH  multiplicand; sampled with `start`.
- `bin`  in  WIDTH  multiplier; sampled with `start`.
- `yout`  out  2*WIDTH  product; registered; holds its value until the next completion.
- `done`  out  1  one-cycle pulse; `yout` is valid from this cycle onward.
- `busy`  out  1  high while in CALC.

## Operation

- The block is a single clock domain with one clock, `clk`. Reset is synchronous and active-high, on `rst`.
- States:
  - IDLE: waits for a request.
  - CALC: iterates.
  - DONE: issues the completion pulse.
- Transitions:
  - IDLE→CALC on a rising edge with `start`=1.
  - CALC→DONE when the iteration ends.
  - DONE→IDLE unconditionally.
- On accept, the block latches `signed_mode`, the magnitudes |ain| and |bin|, and the result sign. The sign is the XOR of the operand MSBs when `signed_mode`=1, and 0 otherwise. In unsigned mode the magnitude is the operand itself.
  - The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), which is representable in WIDTH unsigned bits.
- Each CALC edge does the following:
  - If the multiplier LSB is 1, add the shifted multiplicand into the 2*WIDTH-bit accumulator.
  - Shift the multiplicand left by one.
  - Shift the multiplier right by one.
  - Increment the iteration counter.
- On the final CALC edge, the block writes the accumulator result to `yout`, two's-complement negated when the latched sign is 1.
  - No overflow is possible: the largest signed magnitude is 2^(2·WIDTH−2).
- While in CALC or DONE, the block ignores `start` and the operand inputs. Changing them mid-operation does not affect the result.
- `yout` is not cleared on accept. It changes only on the final CALC edge, or on reset.

## Timing

- Reset values: state = IDLE, `yout` = 0, `done` = 0, `busy` = 0. Internal accumulator and counter are cleared.
- An accept occurs at edge E0. `busy` is 1 from E0 until the final CALC edge.
- Latency without the macro:
  - `done` is high for exactly the cycle between edges E(WIDTH) and E(WIDTH+1).
  - The block is back in IDLE after E(WIDTH+1).
- Back-to-back operation: with `start` held high, the next accept is at E(WIDTH+2). Throughput is one result per WIDTH+2 cycles.
- `done` and `busy` are never high in the same cycle.
- Reset while in CALC or DONE:
  - The operation is aborted and no `done` pulse is issued. All outputs take their reset values on that edge.
  - If `start` is 1 on the first edge with `rst`=0, it is accepted.
- `rst` has priority over `start` on the same edge.

## Configuration

- `MULTI_EARLY_TERM_EN` defined: CALC ends on the first edge after which the remaining shifted multiplier is zero.
  - CALC lasts max(1, p+1) edges, where p is the index of the highest set bit of |bin|.
  - `bin`=0 takes 1 CALC edge and produces `yout`=0.
  - `done` follows the final CALC edge, exactly as in the fixed-latency case.
- `MULTI_EARLY_TERM_EN` undefined: CALC always lasts exactly WIDTH edges, giving fixed latency. The results are identical in both builds.

## Test plan

- Unsigned max (WIDTH=16, macro off): `signed_mode`=0, `ain`=0xFFFF, `bin`=0xFFFF → `yout`=0xFFFE0001. `done` is pulsed for one cycle, 16 edges after accept. `busy` is high for 16 cycles.
- Signed corners (WIDTH=16):
  - `ain`=0x8000, `bin`=0x8000 → 0x40000000.
  - `ain`=0xFFFF, `bin`=0x0003 → 0xFFFFFFFD.
  - `ain`=0x7FFF, `bin`=0x8000 → 0xC0008000.
  - The same 0xFFFF×0x0003 unsigned → 0x0002FFFD.
- Handshake:
  - Hold `start`=1 continuously with the operands changing every cycle. Each result must match the operands present at its accept edge.
  - Successive `done` pulses are 18 cycles apart.
  - `yout` is stable between pulses.
- Reset mid-operation:
  - Assert `rst` for 1 cycle at the 5th CALC cycle. No `done` pulse follows, and `yout`, `busy`, `done` = 0.
  - The next request, 0x1234×0x5678 unsigned, gives 0x06260060.
- Early termination (macro on, WIDTH=16):
  - `bin`=0x0001 → `done` 1 edge after accept.
  - `bin`=0x0000 → 1 edge, `yout`=0.
  - `bin`=0x00F0 → 8 edges.
  - `bin`=0x8000 → 16 edges.
  - Signed `bin`=0xFFFF (magnitude 1) → 1 edge.
- Random sweep: 100 random operations per mode against a behavioural model, at WIDTH=8, 16 and 32, with the macro both on and off. There must be zero mismatches and no operation may exceed WIDTH+2 cycles.

Source files
------------

// File: rtl/multi_nbit_seq.sv
`default_nettype none
// ============================================================================
// Module : multi_nbit_seq
// Iterative shift-add WIDTH x WIDTH multiplier, unsigned or signed per op.
// Option : define MULTI_EARLY_TERM_EN to end iteration once multiplier is zero
// Rev    : 1.0  initial release
// ============================================================================
module multi_nbit_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     ain,
   input  logic [WIDTH-1:0]     bin,
   output logic [2*WIDTH-1:0]   yout,
   output logic                 done,
   output logic                 busy
);
   localparam int              CW     = $clog2(WIDTH);
   localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_mplier;
   logic [CW-1:0]        r_cnt;
   logic                 r_neg;

   logic [WIDTH-1:0]     w_amag;
   logic [WIDTH-1:0]     w_bmag;
   logic                 w_neg;
   logic                 w_last;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [2*WIDTH-1:0]   w_result;

   // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
   assign w_amag     = (signed_mode && ain[WIDTH-1]) ? -ain : ain;
   assign w_bmag     = (signed_mode && bin[WIDTH-1]) ? -bin : bin;
   assign w_neg      = signed_mode & (ain[WIDTH-1] ^ bin[WIDTH-1]);
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_result   = r_neg ? -w_acc_next : w_acc_next;

`ifdef MULTI_EARLY_TERM_EN
   assign w_last = (r_cnt == C_LAST) || ((r_mplier >> 1) == '0);
`else
   assign w_last = (r_cnt == C_LAST);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         yout     <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_amag};
                  r_mplier <= w_bmag;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_neg    <= w_neg;
                  busy     <= 1'b1;
                  r_state  <= S_CALC;
               end
            end
            S_CALC: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  yout    <= w_result;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_nbit_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_multi_nbit_seq
// Directed and random checks of multi_nbit_seq at WIDTH=16.
// Rev    : 1.0  initial release
// ============================================================================
module tb_multi_nbit_seq;
   localparam int W = 16;
`ifdef MULTI_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             signed_mode = 1'b0;
   logic [W-1:0]     ain = '0;
   logic [W-1:0]     bin = '0;
   logic [2*W-1:0]   yout;
   logic             done;
   logic             busy;

   int               n_vec  = 0;
   int               n_fail = 0;
   logic [2*W-1:0]   exp_y  = '0;

   multi_nbit_seq #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .ain         (ain),
      .bin         (bin),
      .yout        (yout),
      .done        (done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      if (sm) begin
         sa = {{W{a[W-1]}}, a};
         sb = {{W{b[W-1]}}, b};
         return sa * sb;
      end
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   function automatic int exp_lat(input logic sm, input logic [W-1:0] b);
      logic [W-1:0] m;
      int p;
      m = (sm && b[W-1]) ? -b : b;
      p = -1;
      for (int i = 0; i < W; i++) if (m[i]) p = i;
      return EARLY ? ((p < 0) ? 1 : p + 1) : W;
   endfunction

   // Entered and left at a falling edge with the block idle.
   task automatic do_op(input string tag, input logic sm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] expv);
      int lat;
      int nbusy;
      signed_mode = sm;
      ain         = a;
      bin         = b;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      ain         = ~a;
      bin         = ~b;
      signed_mode = ~sm;
      @(negedge clk);
      check({tag, " hold"}, yout, exp_y);
      lat   = 0;
      nbusy = 0;
      while (!done && lat < W + 3) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
      check({tag, " lat"}, lat, exp_lat(sm, b));
      check({tag, " busy_cycles"}, nbusy, exp_lat(sm, b));
      check({tag, " busy_at_done"}, busy, 1'b0);
      check({tag, " yout"}, yout, expv);
      exp_y = expv;
      @(negedge clk);
      check({tag, " done_pulse"}, {done, busy}, 2'b00);
   endtask

   initial begin
      int e;
      int results;
      int next_acc;
      int done_at;
      int ndone;
      logic [2*W-1:0] p_exp;
      logic sm;
      logic [W-1:0] a;
      logic [W-1:0] b;

      repeat (3) @(negedge clk);
      check("reset yout", yout, '0);
      check("reset done", done, 1'b0);
      check("reset busy", busy, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      do_op("umax",      1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      do_op("s_min_min", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
      do_op("s_m1_x3",   1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD);
      do_op("s_max_min", 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
      do_op("u_ffff_x3", 1'b0, 16'hFFFF, 16'h0003, 32'h0002FFFD);
      do_op("et_b1",     1'b0, 16'h1234, 16'h0001, 32'h00001234);
      do_op("et_b0",     1'b0, 16'h1234, 16'h0000, 32'h00000000);
      do_op("et_bf0",    1'b0, 16'h1234, 16'h00F0, 32'h001110C0);
      do_op("et_b8000",  1'b0, 16'h1234, 16'h8000, 32'h091A0000);
      do_op("et_sm1",    1'b1, 16'h1234, 16'hFFFF, 32'hFFFFEDCC);

      // start held high, operands changing every cycle
      start    = 1'b1;
      results  = 0;
      e        = 0;
      next_acc = 0;
      done_at  = -1;
      p_exp    = '0;
      while (results < 3 && e < 200) begin
         sm          = 1'($urandom);
         a           = W'($urandom);
         b           = W'($urandom);
         signed_mode = sm;
         ain         = a;
         bin         = b;
         if (e == next_acc) begin
            p_exp    = model(sm, a, b);
            done_at  = e + exp_lat(sm, b);
            next_acc = done_at + 2;
         end
         @(posedge clk);
         @(negedge clk);
         if (e == done_at) begin
            check("hs done", done, 1'b1);
            check("hs yout", yout, p_exp);
            exp_y = p_exp;
            results++;
            if (results == 3) start = 1'b0;
         end else begin
            check("hs no_done", done, 1'b0);
            check("hs yout_stable", yout, exp_y);
         end
         e++;
      end
      check("hs results", results, 3);
      start = 1'b0;
      @(negedge clk);

      // reset during the fifth CALC cycle
      signed_mode = 1'b0;
      ain         = 16'hFFFF;
      bin         = 16'hFFFF;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_mid busy_before", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid outputs", {yout, done, busy}, '0);
      rst   = 1'b0;
      exp_y = '0;
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("rst_mid no_done", ndone, 0);
      do_op("after_rst", 1'b0, 16'h1234, 16'h5678, 32'h06260060);

      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 100; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            do_op(m == 0 ? "rand_u" : "rand_s", 1'(m), a, b, model(1'(m), a, b));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
